demux_1_2_16bit_buf: RTL
========================

# demux_1_2_16bit_buf

Buffered 1-to-2 demultiplexer for 16-bit words: the receive-side counterpart of the 2:1 16-bit select path. It accepts one word per cycle from a single valid/ready source and steers it, per the select bit sampled with the word, into one of two 2-entry output buffers feeding independent sinks A and B. It also keeps a wrap-around transfer count per output.

## Interface
Parameters:
- WIDTH, 16: data word width
- DEPTH, 2: entries per output buffer (fixed at 2 for this block)
- CNT_W, 16: transfer counter width

Ports (all synchronous to `clk`):
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- D  in  WIDTH  input word
- S  in  1  route select, sampled with D: 0 -> A, 1 -> B
- D_valid  in  1  input word valid
- D_ready  out  1  input may be accepted this cycle
- A  out  WIDTH  output A word (head of buffer A)
- A_valid  out  1  buffer A non-empty
- A_ready  in  1  sink A consumes head this cycle
- B  out  WIDTH  output B word (head of buffer B)
- B_valid  out  1  buffer B non-empty
- B_ready  in  1  sink B consumes head this cycle
- CLR  in  1  synchronous clear of both counters
- CNT_A  out  CNT_W  words delivered out of A
- CNT_B  out  CNT_W  words delivered out of B

## Operation
- Input transfer: D_valid && D_ready at a rising edge. D_ready = !rst_n ? 0 : (S ? !full_B : !full_A). D_ready depends combinationally on S and buffer state only, never on A_ready or B_ready.
- An accepted word is written to the tail of the selected buffer. The other buffer is untouched.
- Output transfer: X_valid && X_ready at the edge (X = A or B). This pops the head. X shows the new head, or holds its last value if the buffer is now empty.
- Full buffer: no push, even when a pop occurs in the same cycle. There is no pass-through on full.
- Simultaneous push and pop on a non-full buffer: both take effect, and the occupancy is unchanged.
- Ordering: each buffer is FIFO. There is no ordering guarantee between A and B.
- X_ready while X_valid = 0 is ignored, with no underflow.
- Counters: CNT_X increments on each output transfer of X and wraps from 2^CNT_W-1 to 0. CLR zeroes both counters. If CLR and a transfer happen in the same cycle, CLR wins and the result is 0.
- Reset (rst_n low at an edge): both buffers are emptied, A = B = 0, A_valid = B_valid = 0, CNT_A = CNT_B = 0. D_ready is low while rst_n is low. Words held mid-operation are discarded. Input offered during reset is not accepted.

## Timing
- Latency: a word accepted at edge k into an empty buffer gives X_valid = 1 and X = word from edge k onward, so it is visible in cycle k+1.
- Throughput: 1 word per cycle per buffer when the sink drains every cycle.
- Buffer state per output is an occupancy counter 0..2:
  - 0 to 1 on push.
  - 1 to 2 on push without pop.
  - 1 to 0 on pop without push.
  - 2 to 1 on pop.
  - Push+pop at occupancy 1 stays at 1.
- Read pointer and write pointer are 1 bit each and wrap modulo 2.
- CNT_X updates at the same edge as the output transfer. The new value is visible the following cycle.

## Structure
- Shared package (demux_pkg): WIDTH, DEPTH, CNT_W constants, and the occupancy type (2-bit, values 0..2).
- Sub-module demux_out_buf: 2-entry FIFO with push/pop/full/empty/head plus its own transfer counter and CLR. It is instantiated twice, for A and B.
- The top level holds only the S decode, D_ready generation, and push steering.

## Test plan
- Reset: drive rst_n = 0 for 2 cycles with D_valid = 1. Expect D_ready = 0, A_valid = B_valid = 0, A = B = 0, CNT_A = CNT_B = 0, and no word accepted.
- Steering: send 0x1234 with S = 0, then 0xABCD with S = 1, with A_ready = B_ready = 1. Expect A = 0x1234 with A_valid for 1 cycle, and B = 0xABCD one cycle later. Expect CNT_A = 1, CNT_B = 1.
- Full/backpressure: hold A_ready = 0 and send 0x0001, 0x0002, 0x0003 with S = 0. Expect the first two accepted and D_ready = 0 on the third. Switch S = 1 with 0x0003 and expect immediate acceptance into B.
- Full with simultaneous pop: with A full and A_ready = 1, offer S = 0. Expect D_ready = 0 that cycle, the pop of 0x0001, and acceptance the next cycle. A order must be 0x0001, 0x0002, 0x0003.
- Counter wrap/clear: preload by 65535 A transfers, then one more. Expect CNT_A = 0x0000. Assert CLR in the same cycle as a B transfer and expect CNT_B = 0.
- Reset mid-operation: with both buffers holding 2 words, pulse rst_n low for 1 cycle. Expect both valids low and counters 0 in the next cycle, and none of the old words ever delivered.

Source files
------------

// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
//
// Shared definitions for the buffered 1-to-2 16-bit demultiplexer.
//
// Contents:
//   WIDTH  - data word width (16)
//   DEPTH  - entries per output buffer (fixed at 2)
//   CNT_W  - width of the per-output transfer counters (16)
//   occ_t  - per-buffer occupancy, legal values 0..2
// ---------------------------------------------------------------------------
package demux_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  // Occupancy of one output buffer. The encoding is the plain count, so
  // the value 3 is never reached.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/demux_out_buf.sv
// ---------------------------------------------------------------------------
// demux_out_buf
//
// Two-entry FIFO that feeds one demultiplexer output, plus a wrap-around
// count of the words delivered out of it.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset (empties buffer, zeroes head
//               and counter)
//   push   in   write wdata at the tail (ignored when full)
//   wdata  in   word to write
//   ready  in   sink consumes the head this cycle (ignored when empty)
//   clr    in   synchronous counter clear, wins over a same-cycle transfer
//   head   out  current head word; holds its last value once empty
//   valid  out  buffer non-empty
//   full   out  buffer holds DEPTH words
//   cnt    out  number of words delivered, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module demux_out_buf #(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int DEPTH = demux_pkg::DEPTH,
  parameter int CNT_W = demux_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  input  logic             clr,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] cnt
);

  import demux_pkg::*;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  occ_t             occ;
  occ_t             occ_next;
  logic [WIDTH-1:0] head_next;
  logic             pop;
  logic             do_push;

  assign valid   = (occ != OCC_EMPTY);
  assign full    = (occ == OCC_FULL);
  assign pop     = valid && ready;
  // A full buffer refuses the push even if it is also being popped: there
  // is no pass-through path.
  assign do_push = push && !full;

  always_comb begin
    occ_next = occ;
    case ({do_push, pop})
      2'b10:   occ_next = occ_t'(occ + 2'd1);
      2'b01:   occ_next = occ_t'(occ - 2'd1);
      default: occ_next = occ;
    endcase
  end

  // The head is registered so it can keep showing the last delivered word
  // after the buffer drains, instead of whatever stale slot rd_ptr points
  // at. When the buffer will be non-empty, the new head is the incoming
  // word if it lands in front (buffer was empty, or one entry being
  // popped), otherwise the older entry behind the one being popped.
  always_comb begin
    head_next = head;
    if (occ_next != OCC_EMPTY) begin
      if (occ == OCC_EMPTY || (occ == OCC_ONE && pop)) begin
        head_next = wdata;
      end else if (pop) begin
        head_next = mem[~rd_ptr];
      end
    end
  end

  // Storage array carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ    <= OCC_EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      head   <= '0;
    end else begin
      occ  <= occ_next;
      head <= head_next;
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux_1_2_16bit_buf.sv
// ---------------------------------------------------------------------------
// demux_1_2_16bit_buf
//
// Buffered 1-to-2 demultiplexer for 16-bit words. One valid/ready source is
// steered by S into one of two 2-entry buffers feeding sinks A and B; each
// output keeps a wrap-around count of delivered words.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   D, S                input word and its route select (0 -> A, 1 -> B)
//   D_valid, D_ready    input handshake
//   A, A_valid, A_ready output A head word and handshake
//   B, B_valid, B_ready output B head word and handshake
//   CLR                 synchronous clear of both counters
//   CNT_A, CNT_B        words delivered out of A / B
// ---------------------------------------------------------------------------
module demux_1_2_16bit_buf #(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int DEPTH = demux_pkg::DEPTH,
  parameter int CNT_W = demux_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             S,
  input  logic             D_valid,
  output logic             D_ready,
  output logic [WIDTH-1:0] A,
  output logic             A_valid,
  input  logic             A_ready,
  output logic [WIDTH-1:0] B,
  output logic             B_valid,
  input  logic             B_ready,
  input  logic             CLR,
  output logic [CNT_W-1:0] CNT_A,
  output logic [CNT_W-1:0] CNT_B
);

  logic full_a;
  logic full_b;
  logic accept;
  logic push_a;
  logic push_b;

  // Readiness looks only at the selected buffer's fullness, never at the
  // sinks' ready lines, so no combinational path runs from A/B_ready back
  // to the source.
  assign D_ready = rst_n && (S ? !full_b : !full_a);
  assign accept  = D_valid && D_ready;
  assign push_a  = accept && !S;
  assign push_b  = accept && S;

  demux_out_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_buf_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_a),
    .wdata (D),
    .ready (A_ready),
    .clr   (CLR),
    .head  (A),
    .valid (A_valid),
    .full  (full_a),
    .cnt   (CNT_A)
  );

  demux_out_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_buf_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_b),
    .wdata (D),
    .ready (B_ready),
    .clr   (CLR),
    .head  (B),
    .valid (B_valid),
    .full  (full_b),
    .cnt   (CNT_B)
  );

endmodule
